// File: rtl/alu_pkg.sv
// Shared ALU operation codes for the accumulator datapath.
package alu_pkg;

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluAnd  = 3'b010;
  localparam logic [2:0] AluOr   = 3'b011;
  localparam logic [2:0] AluXor  = 3'b100;
  localparam logic [2:0] AluPass = 3'b101;
  localparam logic [2:0] AluNop  = 3'b111;

endpackage

// File: rtl/useq_pkg.sv
// Microsequencer word layout, sequencing ops, NOP control values and FSM states.
package useq_pkg;

  // ALU codes come from the shared datapath package
  localparam logic [2:0] AluAdd  = alu_pkg::AluAdd;
  localparam logic [2:0] AluSub  = alu_pkg::AluSub;
  localparam logic [2:0] AluAnd  = alu_pkg::AluAnd;
  localparam logic [2:0] AluOr   = alu_pkg::AluOr;
  localparam logic [2:0] AluXor  = alu_pkg::AluXor;
  localparam logic [2:0] AluPass = alu_pkg::AluPass;
  localparam logic [2:0] AluNop  = alu_pkg::AluNop;

  localparam int unsigned WordW      = 19;
  localparam int unsigned RegAddrMsb = 18;
  localparam int unsigned RegAddrLsb = 15;
  localparam int unsigned AluMsb     = 14;
  localparam int unsigned AluLsb     = 12;
  localparam int unsigned RegCeBit   = 11;
  localparam int unsigned CyCeBit    = 10;
  localparam int unsigned ACeBit     = 9;
  localparam int unsigned ResetCyBit = 8;
  localparam int unsigned SeqMsb     = 7;
  localparam int unsigned SeqLsb     = 5;
  localparam int unsigned TgtMsb     = 4;
  localparam int unsigned TgtLsb     = 0;
  localparam int unsigned TgtW       = TgtMsb - TgtLsb + 1;

  typedef enum logic [2:0] {
    SeqInc  = 3'b000,
    SeqJmp  = 3'b001,
    SeqJcy  = 3'b010,
    SeqJncy = 3'b011,
    SeqLdlc = 3'b100,
    SeqLoop = 3'b101,
    SeqHalt = 3'b110,
    SeqRsvd = 3'b111
  } seq_op_e;

  localparam logic [3:0] NopRegAddr = 4'b1111;
  localparam logic [2:0] NopAluCode = AluNop;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  typedef struct packed {
    logic [3:0] reg_addr;
    logic [2:0] alu_code;
    logic       reg_ce;
    logic       cy_ce;
    logic       a_ce;
    logic       reset_cy;
  } ctrl_t;

endpackage

// File: rtl/useq_decode.sv
// Splits a microcode word into datapath controls and SEQ/TGT; forces NOP outside RUN
// and suppresses enables on non-advancing cycles.
module useq_decode import useq_pkg::*; (
  input  logic [WordW-1:0] word_i,
  input  logic             run_i,
  input  logic             step_i,
  output ctrl_t            ctrl_o,
  output seq_op_e          seq_op_o,
  output logic [TgtW-1:0]  tgt_o
);

  always_comb begin
    ctrl_o.reg_addr = NopRegAddr;
    ctrl_o.alu_code = NopAluCode;
    ctrl_o.reg_ce   = 1'b0;
    ctrl_o.cy_ce    = 1'b0;
    ctrl_o.a_ce     = 1'b0;
    ctrl_o.reset_cy = 1'b0;
    if (run_i) begin
      ctrl_o.reg_addr = word_i[RegAddrMsb:RegAddrLsb];
      ctrl_o.alu_code = word_i[AluMsb:AluLsb];
      // Selects stay visible while stalled; only the enables are gated
      if (step_i) begin
        ctrl_o.reg_ce   = word_i[RegCeBit];
        ctrl_o.cy_ce    = word_i[CyCeBit];
        ctrl_o.a_ce     = word_i[ACeBit];
        ctrl_o.reset_cy = word_i[ResetCyBit];
      end
    end
  end

  assign seq_op_o = seq_op_e'(word_i[SeqMsb:SeqLsb]);
  assign tgt_o    = word_i[TgtMsb:TgtLsb];

endmodule

// File: rtl/micro_sequencer.sv
// Start/done microsequencer with carry jumps, loop counter and HALT.
// Define USEQ_SINGLE_STEP_EN to add the 'step' input for single-stepping in RUN.
module micro_sequencer import useq_pkg::*; #(
  parameter int unsigned    AW         = 5,
  parameter int unsigned    LCW        = 4,
  parameter logic [AW-1:0]  START_ADDR = '0
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
`ifdef USEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic [AW-1:0]    ucode_addr,
  input  logic [WordW-1:0] ucode_data,
  input  logic             cy,
  output logic [3:0]       RegAddr,
  output logic [2:0]       ALUCode,
  output logic             Reg_CE,
  output logic             CY_CE,
  output logic             A_CE,
  output logic             ResetCY,
  output logic             busy,
  output logic             done
);

  state_e          state_q, state_d;
  logic [AW-1:0]   upc_q, upc_d;
  logic [LCW-1:0]  lc_q, lc_d;
  logic            step_en;
  ctrl_t           ctrl;
  seq_op_e         seq_op;
  logic [TgtW-1:0] tgt;
  logic [AW-1:0]   tgt_addr;
  logic [AW-1:0]   upc_inc;

`ifdef USEQ_SINGLE_STEP_EN
  assign step_en = step;
`else
  assign step_en = 1'b1;
`endif

  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign tgt_addr = AW'(tgt);
  assign upc_inc  = upc_q + AW'(1);

  useq_decode u_decode (
    .word_i   (ucode_data),
    .run_i    (busy),
    .step_i   (step_en),
    .ctrl_o   (ctrl),
    .seq_op_o (seq_op),
    .tgt_o    (tgt)
  );

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    lc_d    = lc_q;
    unique case (state_q)
      StIdle: begin
        upc_d = START_ADDR;
        if (start) state_d = StRun;
      end
      StRun: begin
        if (step_en) begin
          upc_d = upc_inc;
          case (seq_op)
            SeqJmp:  upc_d = tgt_addr;
            SeqJcy:  if (cy) upc_d = tgt_addr;
            SeqJncy: if (!cy) upc_d = tgt_addr;
            SeqLdlc: lc_d = LCW'(tgt);
            SeqLoop: begin
              if (lc_q != '0) begin
                lc_d  = lc_q - LCW'(1);
                upc_d = tgt_addr;
              end
            end
            SeqHalt: begin
              upc_d   = START_ADDR;
              state_d = StDone;
            end
            default: ;
          endcase
        end
      end
      StDone: begin
        upc_d   = START_ADDR;
        state_d = StIdle;
      end
      default: begin
        upc_d   = START_ADDR;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= StIdle;
      upc_q   <= START_ADDR;
      lc_q    <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      lc_q    <= lc_d;
    end
  end

  assign ucode_addr = upc_q;
  assign RegAddr    = ctrl.reg_addr;
  assign ALUCode    = ctrl.alu_code;
  assign Reg_CE     = ctrl.reg_ce;
  assign CY_CE      = ctrl.cy_ce;
  assign A_CE       = ctrl.a_ce;
  assign ResetCY    = ctrl.reset_cy;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: stimulus queues expected RUN/DONE cycles,
// a negedge monitor pops and compares whenever busy or done is presented.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        cy = 1'b0;
`ifdef USEQ_SINGLE_STEP_EN
  logic        step = 1'b1;
`endif
  logic [4:0]  ucode_addr;
  logic [18:0] ucode_data;
  logic [3:0]  RegAddr;
  logic [2:0]  ALUCode;
  logic        Reg_CE, CY_CE, A_CE, ResetCY, busy, done;

  logic [18:0] rom [32];

  typedef struct packed {
    logic [4:0]  addr;
    logic        busy;
    logic        done;
    logic [10:0] ctrl;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [10:0] Nop = 11'b1111_111_0000;
  localparam logic [2:0] OpInc = 3'b000, OpJmp = 3'b001, OpJcy = 3'b010, OpJncy = 3'b011;
  localparam logic [2:0] OpLdlc = 3'b100, OpLoop = 3'b101, OpHalt = 3'b110, OpRsvd = 3'b111;

  always #5 clk = ~clk;

  assign ucode_data = rom[ucode_addr];

  micro_sequencer dut (
    .clk        (clk),
    .Reset      (Reset),
    .start      (start),
`ifdef USEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .ucode_addr (ucode_addr),
    .ucode_data (ucode_data),
    .cy         (cy),
    .RegAddr    (RegAddr),
    .ALUCode    (ALUCode),
    .Reg_CE     (Reg_CE),
    .CY_CE      (CY_CE),
    .A_CE       (A_CE),
    .ResetCY    (ResetCY),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [18:0] mk(input logic [3:0] ra, input logic [2:0] alu,
                                     input logic [3:0] ce, input logic [2:0] op,
                                     input logic [4:0] tgt);
    return {ra, alu, ce, op, tgt};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = mk(4'b1000, 3'b000, 4'b0000, OpHalt, 5'd0);
  endtask

  task automatic push_run(input logic [4:0] a, input logic [3:0] ce_mask);
    logic [18:0] w;
    w = rom[a];
    exp_q.push_back({a, 1'b1, 1'b0, w[18:12], w[11:8] & ce_mask});
  endtask

  task automatic push_done();
    exp_q.push_back({5'd0, 1'b0, 1'b1, Nop});
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      @(negedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: %0d records pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string name);
    logic [10:0] act;
    act = {RegAddr, ALUCode, Reg_CE, CY_CE, A_CE, ResetCY};
    n_tests++;
    if ({ucode_addr, busy, done, act} !== {5'd0, 1'b0, 1'b0, Nop}) begin
      n_fail++;
      $display("FAIL %s: addr=%0d busy=%b done=%b ctrl=%b, required addr=0 busy=0 done=0 ctrl=%b",
               name, ucode_addr, busy, done, act, Nop);
    end
  endtask

  // Monitor: every cycle with busy or done consumes one expected record
  initial begin
    exp_t        e;
    logic [10:0] act;
    forever begin
      @(negedge clk);
      if (busy || done) begin
        act = {RegAddr, ALUCode, Reg_CE, CY_CE, A_CE, ResetCY};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_cycle: addr=%0d busy=%b done=%b ctrl=%b, required idle",
                   ucode_addr, busy, done, act);
        end else begin
          e = exp_q.pop_front();
          if (busy !== e.busy || done !== e.done || act !== e.ctrl ||
              (e.busy && ucode_addr !== e.addr)) begin
            n_fail++;
            $display("FAIL seq_cycle: addr=%0d busy=%b done=%b ctrl=%b, required addr=%0d busy=%b done=%b ctrl=%b",
                     ucode_addr, busy, done, act, e.addr, e.busy, e.done, e.ctrl);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  localparam logic [2:0] JOps [4] = '{OpJcy, OpJcy, OpJncy, OpJncy};
  localparam logic       JCy  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [4:0] JNext[4] = '{5'd9, 5'd1, 5'd9, 5'd1};

  initial begin
    int k;
    clear_rom();
    repeat (2) @(negedge clk);
    #1 check_idle("reset_state");
    Reset = 1'b0;

    // Straight-line program: three INC/ADD words then HALT
    clear_rom();
    rom[0] = mk(4'b0001, 3'b000, 4'b1010, OpInc, 5'd17);
    rom[1] = mk(4'b0010, 3'b000, 4'b0110, OpInc, 5'd0);
    rom[2] = mk(4'b0100, 3'b000, 4'b1001, OpInc, 5'd3);
    rom[3] = mk(4'b1000, 3'b101, 4'b0001, OpHalt, 5'd0);
    for (int i = 0; i < 4; i++) push_run(5'(i), 4'b1111);
    push_done();
    pulse_start();
    wait_drain("straight", 20);
    @(negedge clk); #1 check_idle("straight_idle");

    // Loop: LDLC 3, body at 1, LOOP->1 at 2, HALT at 3
    clear_rom();
    rom[0] = mk(4'b0001, 3'b000, 4'b0000, OpLdlc, 5'd3);
    rom[1] = mk(4'b0010, 3'b000, 4'b0010, OpInc, 5'd0);
    rom[2] = mk(4'b0100, 3'b001, 4'b0000, OpLoop, 5'd1);
    rom[3] = mk(4'b1000, 3'b111, 4'b0000, OpHalt, 5'd0);
    push_run(5'd0, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      push_run(5'd1, 4'b1111);
      push_run(5'd2, 4'b1111);
    end
    push_run(5'd3, 4'b1111);
    push_done();
    pulse_start();
    wait_drain("loop", 30);
    @(negedge clk); #1 check_idle("loop_idle");

    // Carry jumps
    for (int t = 0; t < 4; t++) begin
      clear_rom();
      rom[0] = mk(4'b0011, 3'b010, 4'b0100, JOps[t], 5'd9);
      rom[1] = mk(4'b0101, 3'b011, 4'b1000, OpHalt, 5'd0);
      rom[9] = mk(4'b0110, 3'b100, 4'b0010, OpHalt, 5'd0);
      cy = JCy[t];
      push_run(5'd0, 4'b1111);
      push_run(JNext[t], 4'b1111);
      push_done();
      pulse_start();
      wait_drain("carry_jump", 20);
    end
    cy = 1'b0;

    // Wrap 31->0, reserved op as INC, LOOP fall-through then taken
    clear_rom();
    rom[0]  = mk(4'b0001, 3'b010, 4'b0001, OpLoop, 5'd4);
    rom[1]  = mk(4'b0010, 3'b000, 4'b0100, OpInc, 5'd0);
    rom[2]  = mk(4'b0100, 3'b000, 4'b0000, OpLdlc, 5'd1);
    rom[3]  = mk(4'b1000, 3'b001, 4'b0000, OpJmp, 5'd30);
    rom[30] = mk(4'b0011, 3'b000, 4'b1000, OpInc, 5'd0);
    rom[31] = mk(4'b1100, 3'b011, 4'b0010, OpRsvd, 5'd7);
    rom[4]  = mk(4'b1001, 3'b101, 4'b0000, OpHalt, 5'd0);
    push_run(5'd0, 4'b1111);
    push_run(5'd1, 4'b1111);
    push_run(5'd2, 4'b1111);
    push_run(5'd3, 4'b1111);
    push_run(5'd30, 4'b1111);
    push_run(5'd31, 4'b1111);
    push_run(5'd0, 4'b1111);
    push_run(5'd4, 4'b1111);
    push_done();
    pulse_start();
    wait_drain("wrap", 30);

    // Reset mid-loop at addr 2 with lc=2, start held during reset
    clear_rom();
    rom[0] = mk(4'b0001, 3'b000, 4'b0000, OpLdlc, 5'd3);
    rom[1] = mk(4'b0010, 3'b000, 4'b0010, OpInc, 5'd0);
    rom[2] = mk(4'b0100, 3'b001, 4'b1111, OpLoop, 5'd1);
    rom[3] = mk(4'b1000, 3'b111, 4'b0000, OpHalt, 5'd0);
    push_run(5'd0, 4'b1111);
    push_run(5'd1, 4'b1111);
    push_run(5'd2, 4'b1111);
    push_run(5'd1, 4'b1111);
    push_run(5'd2, 4'b1111);
    pulse_start();
    wait_drain("pre_reset", 20);
    Reset = 1'b1;
    start = 1'b1;
    @(negedge clk); #1 check_idle("reset_mid_run");
    @(negedge clk); #1;
    Reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_idle("after_reset");
    // lc must be 0: LOOP at 0 falls through to HALT at 1
    clear_rom();
    rom[0] = mk(4'b0001, 3'b110, 4'b0000, OpLoop, 5'd3);
    rom[1] = mk(4'b0010, 3'b000, 4'b0001, OpHalt, 5'd0);
    rom[3] = mk(4'b0100, 3'b000, 4'b0010, OpHalt, 5'd0);
    push_run(5'd0, 4'b1111);
    push_run(5'd1, 4'b1111);
    push_done();
    pulse_start();
    wait_drain("lc_cleared", 20);

    // start held high: one run per IDLE entry, ignored in RUN/DONE
    clear_rom();
    rom[0] = mk(4'b1000, 3'b011, 4'b1111, OpHalt, 5'd0);
    push_run(5'd0, 4'b1111);
    push_done();
    push_run(5'd0, 4'b1111);
    push_done();
    @(negedge clk); #1 start = 1'b1;
    k = 0;
    while (exp_q.size() > 1 && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    start = 1'b0;
    wait_drain("held_start", 20);
    repeat (3) @(negedge clk);
    #1 check_idle("held_start_idle");

`ifdef USEQ_SINGLE_STEP_EN
    // Three stalled cycles at addr 1, then one stepped advance
    clear_rom();
    rom[0] = mk(4'b0001, 3'b000, 4'b1111, OpInc, 5'd0);
    rom[1] = mk(4'b0010, 3'b001, 4'b1111, OpInc, 5'd0);
    rom[2] = mk(4'b0100, 3'b010, 4'b1111, OpInc, 5'd0);
    rom[3] = mk(4'b1000, 3'b011, 4'b1111, OpHalt, 5'd0);
    push_run(5'd0, 4'b1111);
    for (int i = 0; i < 3; i++) push_run(5'd1, 4'b0000);
    push_run(5'd1, 4'b1111);
    push_run(5'd2, 4'b1111);
    push_run(5'd3, 4'b1111);
    push_done();
    @(negedge clk); #1 start = 1'b1;
    step = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 step = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1 step = 1'b1;
    wait_drain("single_step", 20);
    @(negedge clk); #1 check_idle("step_idle");
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Replaces the free-running program counter plus hard-wired microprogram with a start/done-controlled microsequencer for the accumulator datapath.
- Fetches words from an external combinational-read microcode ROM and drives the datapath control strobes.
- Adds conditional jumps on the carry flag, a hardware loop counter and a HALT that returns to idle.

Parameters:
- AW, 5, micro-PC / ROM address width.
- LCW, 4, loop-counter width.
- START_ADDR, 0, micro-PC loaded on start.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  begin execution at START_ADDR; sampled only in IDLE.
- ucode_addr  out  AW  ROM address, equal to the micro-PC.
- ucode_data  in  19  ROM word for ucode_addr, valid in the same cycle.
- cy  in  1  datapath carry flag (registered value).
- RegAddr  out  4  one-hot register select.
- ALUCode  out  3  ALU operation, using the shared ALU codes.
- Reg_CE  out  1  register-file write enable.
- CY_CE  out  1  carry-flag enable.
- A_CE  out  1  accumulator enable.
- ResetCY  out  1  carry-flag clear.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after HALT.

Behaviour:
- Word fields:
  - [18:15] RegAddr, [14:12] ALUCode, [11] Reg_CE, [10] CY_CE, [9] A_CE, [8] ResetCY.
  - [7:5] SEQ op, [4:0] TGT.
- SEQ ops:
  - 000 INC: upc+1.
  - 001 JMP: upc=TGT.
  - 010 JCY: TGT if cy=1, else upc+1.
  - 011 JNCY: TGT if cy=0, else upc+1.
  - 100 LDLC: lc=TGT[LCW-1:0], upc+1.
  - 101 LOOP: if lc!=0 then lc-=1 and upc=TGT, else upc+1.
  - 110 HALT.
  - 111 reserved, behaves as INC.
- States IDLE, RUN, DONE.
  - IDLE: upc held at START_ADDR. start=1 -> RUN at the next edge.
  - RUN: every cycle executes the word at upc. Next upc per SEQ op. HALT -> DONE; the HALT word's control fields are still driven in its cycle.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Control outputs:
  - In RUN they are combinational from ucode_data: one instruction per cycle, zero added latency.
  - In IDLE/DONE they drive NOP: RegAddr=4'b1111, ALUCode=3'b111, all CEs=0, ResetCY=0.
- Carry tests use cy as sampled in the current cycle, i.e. the flag produced by earlier instructions, not by the instruction being executed.
- A LOOP with lc=N jumps N times, so a body ending in LOOP executes N+1 times. lc is unchanged by all other ops.
- Wrap-around:
  - upc+1 from 2^AW-1 wraps to 0.
  - JMP/JCY use TGT[AW-1:0].
- Edge cases:
  - start in RUN/DONE is ignored.
  - start held high in IDLE triggers exactly one run per IDLE entry.
- Reset (any state, including mid-program): state=IDLE, upc=START_ADDR, lc=0, busy=0, done=0, outputs NOP. Reset wins over start.

Optional Feature:
- Macro USEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - In RUN, upc, lc and state advance only on cycles with step=1.
  - On step=0 cycles all CE outputs and ResetCY are forced 0; RegAddr/ALUCode still reflect the word.
  - HALT completes only on a stepped cycle.
- Undefined: no step port; behaves as if step=1.

Decomposition:
- Package useq_pkg holds:
  - SEQ op constants and word field bit positions/widths.
  - NOP control values and the state enum.
  - ALU codes re-exported from the shared ALU defines; not redefined.
- One natural sub-module, useq_decode: combinational split of ucode_data into control fields and SEQ/TGT, applying NOP forcing.
- FSM, upc and lc stay in micro_sequencer.

Test Plan:
- Reset then start=1 for one cycle; ROM 0..2 INC with ALUCode ADD, word 3 HALT -> ucode_addr 0,1,2,3; busy high 4 cycles; done pulses in cycle 5; outputs NOP after.
- Word 0 LDLC TGT=3; word 1 A_CE=1 INC; word 2 LOOP TGT=1; word 3 HALT -> word 1 executes 4 times, lc ends 0, 10 RUN cycles total.
- Word 0 JCY TGT=9 with cy=1 -> next addr 9; repeat with cy=0 -> next addr 1; same for JNCY inverted.
- ROM all INC from START_ADDR=30 -> addresses 30,31,0,1; reserved op 111 behaves as INC.
- Assert Reset during a loop at addr 2 with lc=2 -> next cycle IDLE, lc=0, upc=START_ADDR, all CEs 0, no done pulse; start held during Reset ignored.
- With USEQ_SINGLE_STEP_EN, step=0 for 3 cycles in RUN -> upc frozen, CEs 0; step=1 -> advances by one.
